bpm_divider_arbiter: RTL and testbench



---
 rtl/bpm_divider_arbiter.sv | 123 ++++++++++++
 tb/tb_bpm_divider_arbiter.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/bpm_divider_arbiter.sv
// Two-channel round-robin front end sharing one 32-step restoring divider that turns beat intervals into BPM.
// Optional BPM_DIV_ROUND_EN: adds interval/2 to the dividend for round-to-nearest results.
module bpm_divider_arbiter #(
    parameter int CLOCK_FREQ = 50_000_000,
    parameter int BPM_WIDTH  = 16,
    parameter int MIN_BPM    = 40,
    parameter int MAX_BPM    = 200
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [31:0]          req0_interval,
    input  logic [31:0]          req1_interval,
    input  logic                 req0_valid,
    input  logic                 req1_valid,
    output logic                 req0_ready,
    output logic                 req1_ready,
    output logic [BPM_WIDTH-1:0] bpm0_data,
    output logic [BPM_WIDTH-1:0] bpm1_data,
    output logic                 bpm0_valid,
    output logic                 bpm1_valid,
    output logic                 bpm0_err,
    output logic                 bpm1_err,
    output logic                 busy
);

    localparam logic [63:0] NUM_64       = 64'(CLOCK_FREQ) * 64'd60;
    localparam logic [31:0] NUM          = NUM_64[31:0];
    localparam logic [31:0] MIN_INTERVAL = 32'(NUM_64 / 64'(MAX_BPM));
    localparam logic [31:0] MAX_INTERVAL = 32'(NUM_64 / 64'(MIN_BPM));

    typedef enum logic [1:0] {IDLE, DIV, DONE} state_t;

    state_t      state, state_next;
    logic        last_grant;
    logic        grant;
    logic        accept;
    logic        ch;
    logic        err;
    logic        in_range;
    logic [31:0] acc_interval;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic [31:0] quot;
    logic [32:0] rem;
    logic [33:0] rem_shift;
    logic        ge;
    logic [5:0]  iter;

    // Arbitration: a tie goes to the channel that did not win last time.
    always_comb begin
        accept = reset_n && (state == IDLE) && (req0_valid || req1_valid);
        if (req0_valid && req1_valid)
            grant = ~last_grant;
        else
            grant = req1_valid;
        acc_interval = grant ? req1_interval : req0_interval;
        in_range     = (acc_interval >= MIN_INTERVAL) && (acc_interval <= MAX_INTERVAL);
`ifdef BPM_DIV_ROUND_EN
        dividend     = NUM + (acc_interval >> 1);
`else
        dividend     = NUM;
`endif
    end

    assign req0_ready = accept && !grant;
    assign req1_ready = accept && grant;

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (accept) state_next = in_range ? DIV : DONE;
            DIV:  if (iter == 6'd31) state_next = DONE;
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            ch         <= 1'b0;
            err        <= 1'b0;
        end else begin
            state <= state_next;
            if (accept) begin
                last_grant <= grant;
                ch         <= grant;
                err        <= !in_range;
            end
        end
    end

    // Dividend bits shift out of quot's MSB while quotient bits shift in at its LSB.
    always_comb begin
        rem_shift = {rem, quot[31]};
        ge        = rem_shift >= {2'b00, divisor};
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            divisor <= acc_interval;
            quot    <= dividend;
            rem     <= '0;
            iter    <= '0;
        end else if (state == DIV) begin
            rem  <= ge ? 33'(rem_shift - {2'b00, divisor}) : rem_shift[32:0];
            quot <= {quot[30:0], ge};
            iter <= iter + 6'd1;
        end
    end

    always_comb begin
        bpm0_valid = (state == DONE) && !ch;
        bpm1_valid = (state == DONE) && ch;
        bpm0_err   = bpm0_valid && err;
        bpm1_err   = bpm1_valid && err;
        bpm0_data  = (bpm0_valid && !err) ? quot[BPM_WIDTH-1:0] : '0;
        bpm1_data  = (bpm1_valid && !err) ? quot[BPM_WIDTH-1:0] : '0;
        busy       = (state != IDLE);
    end

endmodule

// File: tb/tb_bpm_divider_arbiter.sv
// Directed self-checking bench for bpm_divider_arbiter: latency, range limits, tie arbitration and reset abort.
module tb_bpm_divider_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] req0_interval, req1_interval;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [15:0] bpm0_data, bpm1_data;
    logic        bpm0_valid, bpm1_valid;
    logic        bpm0_err, bpm1_err;
    logic        busy;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    bpm_divider_arbiter dut (
        .clk(clk), .reset_n(reset_n),
        .req0_interval(req0_interval), .req1_interval(req1_interval),
        .req0_valid(req0_valid), .req1_valid(req1_valid),
        .req0_ready(req0_ready), .req1_ready(req1_ready),
        .bpm0_data(bpm0_data), .bpm1_data(bpm1_data),
        .bpm0_valid(bpm0_valid), .bpm1_valid(bpm1_valid),
        .bpm0_err(bpm0_err), .bpm1_err(bpm1_err),
        .busy(busy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic vld_of(input logic c);
        return c ? bpm1_valid : bpm0_valid;
    endfunction

    function automatic logic rdy_of(input logic c);
        return c ? req1_ready : req0_ready;
    endfunction

    function automatic logic err_of(input logic c);
        return c ? bpm1_err : bpm0_err;
    endfunction

    function automatic logic [15:0] data_of(input logic c);
        return c ? bpm1_data : bpm0_data;
    endfunction

    task automatic set_req(input logic c, input logic v, input logic [31:0] iv);
        if (c) begin req1_valid = v; req1_interval = iv; end
        else   begin req0_valid = v; req0_interval = iv; end
    endtask

    // Waits for the channel strobe starting in cycle T+1; returns the latency relative to T.
    task automatic wait_strobe(input logic c, output int lat, output logic other_seen);
        lat = 1;
        other_seen = 1'b0;
        while (!vld_of(c) && lat < 100) begin
            if (vld_of(!c)) other_seen = 1'b1;
            step();
            lat++;
        end
    endtask

    task automatic run_req(input string tag, input logic c, input logic [31:0] iv,
                           input int exp_data, input logic exp_err, input int exp_lat);
        int   k;
        int   lat;
        logic other_seen;
        set_req(c, 1'b1, iv);
        #1;
        k = 0;
        while (!rdy_of(c) && k < 100) begin
            step();
            k++;
        end
        chk({tag, " ready"}, 32'(rdy_of(c)), 32'd1);
        step();
        set_req(c, 1'b0, iv);
        wait_strobe(c, lat, other_seen);
        chk({tag, " latency"}, lat, exp_lat);
        chk({tag, " data"}, 32'(data_of(c)), exp_data);
        chk({tag, " err"}, 32'(err_of(c)), 32'(exp_err));
        chk({tag, " other idle"}, 32'(other_seen || vld_of(!c)), 32'd0);
        step();
        chk({tag, " one-cycle"}, 32'(vld_of(c)), 32'd0);
        chk({tag, " busy after"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int   lat;
        int   k;
        logic other_seen;
        int   exp_round;

        reset_n = 1'b0;
        req0_valid = 1'b1; req0_interval = 32'd30_000_000;
        req1_valid = 1'b1; req1_interval = 32'd20_000_000;
        step();
        step();
        chk("reset ready0", 32'(req0_ready), 32'd0);
        chk("reset ready1", 32'(req1_ready), 32'd0);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset bpm0_valid", 32'(bpm0_valid), 32'd0);
        chk("reset bpm1_valid", 32'(bpm1_valid), 32'd0);
        chk("reset bpm0_data", 32'(bpm0_data), 32'd0);

        // Tie immediately after reset: req0 wins first.
        reset_n = 1'b1;
        #1;
        chk("tie1 ready0", 32'(req0_ready), 32'd1);
        chk("tie1 ready1", 32'(req1_ready), 32'd0);
        step();
        req0_valid = 1'b0;
        chk("tie1 busy", 32'(busy), 32'd1);
        wait_strobe(1'b0, lat, other_seen);
        chk("tie1 latency", lat, 33);
        chk("tie1 data", 32'(bpm0_data), 32'd100);
        chk("tie1 other idle", 32'(other_seen), 32'd0);
        req0_valid = 1'b1;
        step();
        chk("tie2 ready1", 32'(req1_ready), 32'd1);
        chk("tie2 ready0", 32'(req0_ready), 32'd0);
        step();
        req1_valid = 1'b0;
        wait_strobe(1'b1, lat, other_seen);
        chk("tie2 latency", lat, 33);
        chk("tie2 data", 32'(bpm1_data), 32'd150);
        chk("tie2 err", 32'(bpm1_err), 32'd0);
        req1_valid = 1'b1;
        step();
        chk("tie3 ready0", 32'(req0_ready), 32'd1);
        chk("tie3 ready1", 32'(req1_ready), 32'd0);
        req1_valid = 1'b0;
        step();
        req0_valid = 1'b0;
        wait_strobe(1'b0, lat, other_seen);
        chk("tie3 latency", lat, 33);
        chk("tie3 data", 32'(bpm0_data), 32'd100);
        step();

        run_req("r0 120", 1'b0, 32'd25_000_000, 120, 1'b0, 33);
        run_req("r1 max", 1'b1, 32'd15_000_000, 200, 1'b0, 33);
        run_req("r1 min", 1'b1, 32'd75_000_000, 40, 1'b0, 33);
        run_req("r0 fast", 1'b0, 32'd14_999_999, 0, 1'b1, 1);
        run_req("r0 slow", 1'b0, 32'd75_000_001, 0, 1'b1, 1);
`ifdef BPM_DIV_ROUND_EN
        exp_round = 135;
`else
        exp_round = 134;
`endif
        run_req("r1 round", 1'b1, 32'd22_222_223, exp_round, 1'b0, 33);

        // Reset in the middle of a division.
        set_req(1'b0, 1'b1, 32'd25_000_000);
        #1;
        k = 0;
        while (!req0_ready && k < 100) begin step(); k++; end
        chk("abort ready", 32'(req0_ready), 32'd1);
        step();
        req0_valid = 1'b0;
        repeat (9) step();
        reset_n = 1'b0;
        step();
        chk("abort busy", 32'(busy), 32'd0);
        chk("abort strobe", 32'(bpm0_valid), 32'd0);
        reset_n = 1'b1;
        other_seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (bpm0_valid || bpm1_valid) other_seen = 1'b1;
            step();
        end
        chk("abort no strobe", 32'(other_seen), 32'd0);
        run_req("post reset", 1'b0, 32'd30_000_000, 100, 1'b0, 33);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
